rf_dump_ctrl: RTL
=================

RF_DUMP_CTRL -- requirements
Module: rf_dump_ctrl

Interface
REQ-001 Parameter NREGS, 32, number of architectural registers scanned.
REQ-002 Parameter AW, 5, register index width.
REQ-003 Parameter DW, 32, register data width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a dump; ignored while busy=1.
REQ-007 mode  in  1  sampled with start: 0 = full dump of indices 0..NREGS-1, 1 = single register.
REQ-008 sel_in  in  AW  register index for mode 1, sampled with start.
REQ-009 abort  in  1  synchronous cancel of a dump in progress.
REQ-010 reg_sel  out  AW  index driven to the register-file debug read port.
REQ-011 reg_data  in  DW  combinational debug read data; index 0 reads as 0.
REQ-012 wr_en, wr_addr  in  1, AW  snoop copy of the register-file write enable and write address.
REQ-013 out_valid, out_ready  out, in  1, 1  valid/ready handshake for dumped words.
REQ-014 out_idx, out_data  out  AW, DW  index and value of the current dumped word.
REQ-015 busy, done, dirty  out  1, 1, 1  dump active; one-cycle completion pulse; sticky consistency warning.

Function
REQ-016 FSM states: IDLE, SEL, SEND, DONE.
REQ-017 IDLE: busy=0, reg_sel=0, out_valid=0; start=1 -> latch mode, idx = (mode ? sel_in : 0), clear dirty and cap_any, go to SEL.
REQ-018 SEL (one cycle): reg_sel=idx; at the clock edge out_data<=reg_data, out_idx<=idx, out_valid<=1, cap_hi<=idx, cap_any<=1; go to SEND.
REQ-019 SEND: out_valid, out_idx and out_data held stable until out_ready=1.
REQ-020 Handshake in SEND: out_valid=1 and out_ready=1 at the clock edge; out_valid drops the next cycle unless a new word follows.
REQ-021 On handshake: if mode=1 or idx=NREGS-1, go to DONE; otherwise idx<=idx+1 and go to SEL.
REQ-022 Throughput: with out_ready tied high, one word per 2 cycles.
REQ-023 Latency: full dump is start -> done in 2*NREGS+2 cycles.
REQ-024 DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
REQ-025 busy=1 in SEL and SEND only.
REQ-026 dirty sets when busy=1, cap_any=1, wr_en=1, wr_addr!=0 and wr_addr<=cap_hi (an already-captured word is stale).
REQ-027 dirty also sets on a write in the same cycle as its SEL capture.
REQ-028 dirty holds until the next accepted start.
REQ-029 A write to index 0 never sets dirty.
REQ-030 abort=1 in SEL or SEND: next state IDLE, out_valid=0, no done pulse; dirty retains its value.
REQ-031 abort has priority over a simultaneous handshake; abort in IDLE or DONE has no effect.
REQ-032 start asserted while busy=1 or in DONE is dropped, not queued.
REQ-033 idx never wraps; increment occurs only below NREGS-1.
REQ-034 sel_in >= NREGS in mode 1 is clamped to NREGS-1.

Reset
REQ-035 On rst: state=IDLE; busy, done and out_valid are 0; dirty, cap_any, cap_hi, idx, reg_sel, out_idx and out_data are 0.
REQ-036 rst asserted mid-dump abandons the dump immediately with no done pulse.

Structure
REQ-037 Shared package holds the FSM state encoding, the NREGS/AW/DW defaults and the mode encodings.
REQ-038 Implementation is a single module with no sub-modules; the output word register is the only datapath storage.

Verification
REQ-039 Full dump: RF[i]=i*0x11111111 for i>=1, mode=0, out_ready=1 -> 32 words with idx 0..31 and data 0, 0x11111111, ...; done at cycle 66; dirty=0.
REQ-040 Backpressure: out_ready low for 5 cycles on word 3 -> out_idx=3 and out_data held stable throughout; no word skipped or duplicated.
REQ-041 Single read: mode=1, sel_in=7, RF[7]=0xDEADBEEF -> one word (7, 0xDEADBEEF) followed by done.
REQ-042 Snoop: write to reg 2 after word 5 is captured -> dirty=1 until the next start; write to reg 20 at the same point -> dirty stays 0; write to reg 0 -> dirty stays 0.
REQ-043 Abort at word 10 in SEND with simultaneous out_ready -> IDLE next cycle, out_valid=0, no done; a fresh start then dumps from idx 0.
REQ-044 Async rst mid-SEND -> all outputs 0 before the next clock edge; start while busy is ignored.

Source files
------------

// File: rtl/rf_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump controller: default sizes,
// FSM state encoding and dump mode encodings.
package rf_dump_ctrl_pkg;

    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_FULL   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/rf_dump_ctrl_if.sv
// Bundle of the register-file debug port, write snoop and dumped-word stream.
interface rf_dump_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] reg_sel;
    logic [DW-1:0] reg_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    modport master (
        output reg_sel,
        input  reg_data,
        input  wr_en,
        input  wr_addr,
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_data
    );

    modport slave (
        input  reg_sel,
        output reg_data,
        output wr_en,
        output wr_addr,
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_data
    );
endinterface

// File: rtl/rf_dump_ctrl.sv
// Streams register-file contents out over a valid/ready port, one word per
// two cycles, and flags words made stale by writes during the dump.
//
// state   | meaning
// IDLE    | waiting for start; debug port parked at index 0
// SEL     | debug port driven with idx, word captured at the clock edge
// SEND    | captured word offered on the output until accepted
// DONE    | one-cycle completion pulse
module rf_dump_ctrl
    import rf_dump_ctrl_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic [AW-1:0] i_sel_in,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_dirty,
    rf_dump_ctrl_if.master bus
);

    localparam logic [AW-1:0] LP_LAST = AW'(NREGS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mode;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_cap_hi;
    logic          r_cap_any;
    logic          r_dirty;
    logic          r_out_valid;
    logic [AW-1:0] r_out_idx;
    logic [DW-1:0] r_out_data;

    logic [AW-1:0] w_reg_sel;
    logic [AW-1:0] w_sel_clamped;
    logic          w_accept;
    logic          w_handshake;
    logic          w_last;
    logic          w_dirty_set;

    assign w_sel_clamped = (i_sel_in > LP_LAST) ? LP_LAST : i_sel_in;
    assign w_accept      = (r_state == ST_IDLE) && i_start;
    assign w_handshake   = (r_state == ST_SEND) && r_out_valid && bus.out_ready;
    assign w_last        = (r_mode == MODE_SINGLE) || (r_idx == LP_LAST);

    // A write in the SEL cycle lands after the capture, so it is stale too.
    assign w_dirty_set = o_busy && bus.wr_en && (bus.wr_addr != '0) &&
                         ((r_cap_any && (bus.wr_addr <= r_cap_hi)) ||
                          ((r_state == ST_SEL) && (bus.wr_addr <= r_idx)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SEL;
                end
            end
            ST_SEL: begin
                w_state_nxt = i_abort ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_handshake) begin
                    w_state_nxt = w_last ? ST_DONE : ST_SEL;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy    = 1'b0;
        o_done    = 1'b0;
        w_reg_sel = '0;
        case (r_state)
            ST_SEL: begin
                o_busy    = 1'b1;
                w_reg_sel = r_idx;
            end
            ST_SEND: begin
                o_busy    = 1'b1;
                w_reg_sel = r_idx;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= MODE_FULL;
            r_idx       <= '0;
            r_cap_hi    <= '0;
            r_cap_any   <= 1'b0;
            r_dirty     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_mode    <= i_mode;
                r_idx     <= (i_mode == MODE_SINGLE) ? w_sel_clamped : '0;
                r_dirty   <= 1'b0;
                r_cap_any <= 1'b0;
            end else if (w_dirty_set) begin
                r_dirty <= 1'b1;
            end

            if ((r_state == ST_SEL) && !i_abort) begin
                r_out_data  <= bus.reg_data;
                r_out_idx   <= r_idx;
                r_out_valid <= 1'b1;
                r_cap_hi    <= r_idx;
                r_cap_any   <= 1'b1;
            end

            if (r_state == ST_SEND) begin
                if (i_abort || bus.out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (!i_abort && w_handshake && !w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_dirty       = r_dirty;
    assign bus.reg_sel   = w_reg_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_data  = r_out_data;

endmodule
